// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix keypad model driven by a valid/ready press request.
// Optional contact bounce at press and release: define KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 64,
    parameter int GAP_CYCLES    = 16,
    parameter int BOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       key_done,
    input  logic       R1,
    input  logic       R2,
    input  logic       R3,
    input  logic       R4,
    output logic       C1,
    output logic       C2,
    output logic       C3,
    output logic       C4
);

    localparam int MAXHG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAXP  = (MAXHG > BOUNCE_CYCLES) ? MAXHG : BOUNCE_CYCLES;
    localparam int CW    = $clog2(MAXP + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HOLD = 3'd2;
    localparam logic [2:0] GAP  = 3'd4;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [2:0] BOUNCE_IN  = 3'd1;
    localparam logic [2:0] BOUNCE_OUT = 3'd3;
    localparam logic [CW-1:0] BNC_LAST = CW'(BOUNCE_CYCLES - 1);
    localparam logic [2:0] PRESS_ST = BOUNCE_IN;
`else
    localparam logic [2:0] PRESS_ST = HOLD;
`endif

    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    code, code_n;
    logic [3:0]    cq, cq_n;
    logic [3:0]    rows;
    logic          contact;
    logic          row_hit;
    logic          accept;

    assign rows = {R4, R3, R2, R1};

    // Finishing edge of the gap doubles as the earliest next handshake.
    always_comb begin
        key_done  = (state == GAP) && (cnt == GAP_LAST);
        key_ready = (state == IDLE) || key_done;
        accept    = key_valid && key_ready;
    end

    // Contact closure as a function of state and position within it.
    always_comb begin
        contact = 1'b0;
        case (state)
            HOLD:       contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            BOUNCE_IN:  contact = ~cnt[1];
            BOUNCE_OUT: contact = ~cnt[1];
`endif
            default:    contact = 1'b0;
        endcase
    end

    // Press sequencing: next state, cycle counter and latched key code.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        code_n  = code;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    code_n  = key_code;
                    state_n = PRESS_ST;
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            BOUNCE_IN: begin
                if (cnt == BNC_LAST) begin
                    cnt_n   = '0;
                    state_n = HOLD;
                end
            end
            BOUNCE_OUT: begin
                if (cnt == BNC_LAST) begin
                    cnt_n   = '0;
                    state_n = GAP;
                end
            end
`endif
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n = '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_n = BOUNCE_OUT;
`else
                    state_n = GAP;
`endif
                end
            end
            GAP: begin
                if (key_done) begin
                    cnt_n = '0;
                    if (accept) begin
                        code_n  = key_code;
                        state_n = PRESS_ST;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Only the latched row can close onto the latched column.
    always_comb begin
        row_hit         = rows[code[3:2]];
        cq_n            = 4'b0000;
        cq_n[code[1:0]] = contact & row_hit;
    end

    // State, counter, code and column return registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= 4'b0000;
            cq    <= 4'b0000;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            code  <= code_n;
            cq    <= cq_n;
        end
    end

    assign C1 = cq[0];
    assign C2 = cq[1];
    assign C3 = cq[2];
    assign C4 = cq[3];

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: table vectors, corner sequences and random press traffic
// checked against a timeline model of the keypad emulator.
module tb_keypad_emulator;

    localparam int H = 4;
    localparam int G = 2;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int B   = 8;
    localparam int LEN = H + G + 2 * B;
`else
    localparam int LEN = H + G;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       key_ready, key_done;
    logic [3:0] r = 4'b0000;
    logic       C1, C2, C3, C4;
    logic [3:0] cv;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: offset since acceptance (-1 idle) and latched code.
    int         mk = -1;
    logic [3:0] mcode = 4'd0;
    logic       s_rdy, s_done;

    assign cv = {C4, C3, C2, C1};

    keypad_emulator #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES(G),
        .BOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_ready(key_ready),
        .key_done(key_done),
        .R1(r[0]),
        .R2(r[1]),
        .R3(r[2]),
        .R4(r[3]),
        .C1(C1),
        .C2(C2),
        .C3(C3),
        .C4(C4)
    );

    always #5 clk = ~clk;

    function automatic logic contact_at(int k);
        if (k < 0) return 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
        if (k < B) return ((k / 2) % 2) == 0;
        if (k < B + H) return 1'b1;
        if (k < 2 * B + H) return (((k - B - H) / 2) % 2) == 0;
        return 1'b0;
`else
        return k < H;
`endif
    endfunction

    task automatic chk(string name, logic [3:0] got, logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    // One clock: check handshake outputs, advance model, check columns.
    task automatic step();
        logic       rdy_e, done_e, con;
        logic [3:0] ce;
        #1;
        con    = contact_at(mk);
        done_e = (mk == LEN - 1);
        rdy_e  = (mk < 0) || done_e;
        s_rdy  = key_ready;
        s_done = key_done;
        chk("ready", {3'b0, key_ready}, {3'b0, rdy_e});
        chk("done", {3'b0, key_done}, {3'b0, done_e});
        ce = 4'b0000;
        if (con && r[mcode[3:2]]) ce = 4'b0001 << mcode[1:0];
        @(posedge clk);
        cyc++;
        if (rdy_e && key_valid) begin
            mk    = 0;
            mcode = key_code;
        end else if (mk >= 0) begin
            mk = (mk == LEN - 1) ? -1 : mk + 1;
        end
        #1;
        chk("cols", cv, ce);
    endtask

    task automatic reset_check(string name);
        #3;
        rst = 1'b0;
        #1;
        mk    = -1;
        mcode = 4'd0;
        chk({name, "_cols"}, cv, 4'b0000);
        chk({name, "_ready"}, {3'b0, key_ready}, 4'b0001);
        chk({name, "_done"}, {3'b0, key_done}, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [3:0] code;
        logic [3:0] r;
        logic       rdy;
        logic       done;
        logic [3:0] c;
    } vec_t;

    vec_t tbl[8];

    initial begin
`ifdef KEYPAD_EMU_BOUNCE_EN
        logic [0:LEN-1] expv;
        logic [0:LEN-1] gotv;
`endif
        tbl[0] = '{1'b1, 4'd6, 4'b0010, 1'b1, 1'b0, 4'b0000};
        tbl[1] = '{1'b0, 4'd6, 4'b0010, 1'b0, 1'b0, 4'b0100};
        tbl[2] = '{1'b0, 4'd9, 4'b0010, 1'b0, 1'b0, 4'b0100};
        tbl[3] = '{1'b0, 4'd6, 4'b1101, 1'b0, 1'b0, 4'b0000};
        tbl[4] = '{1'b0, 4'd6, 4'b0010, 1'b0, 1'b0, 4'b0100};
        tbl[5] = '{1'b0, 4'd6, 4'b0010, 1'b0, 1'b0, 4'b0000};
        tbl[6] = '{1'b0, 4'd6, 4'b0010, 1'b1, 1'b1, 4'b0000};
        tbl[7] = '{1'b0, 4'd6, 4'b0010, 1'b1, 1'b0, 4'b0000};

        // Reset with every row strobe high.
        r = 4'b1111;
        #2;
        chk("rst_cols", cv, 4'b0000);
        chk("rst_ready", {3'b0, key_ready}, 4'b0001);
        chk("rst_done", {3'b0, key_done}, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        r   = 4'b0000;
        step();

`ifndef KEYPAD_EMU_BOUNCE_EN
        // Directed press of code 6 with R2 strobing.
        for (int i = 0; i < 8; i++) begin
            key_valid = tbl[i].v;
            key_code  = tbl[i].code;
            r         = tbl[i].r;
            step();
            chk($sformatf("tbl%0d_rdy", i), {3'b0, s_rdy}, {3'b0, tbl[i].rdy});
            chk($sformatf("tbl%0d_done", i), {3'b0, s_done}, {3'b0, tbl[i].done});
            chk($sformatf("tbl%0d_c", i), cv, tbl[i].c);
        end
`else
        // Bounced press of code 0 with R1 held high.
        expv = 22'b1100110011111100110000;
        key_valid = 1'b1;
        key_code  = 4'd0;
        r         = 4'b0001;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            step();
            gotv[i] = C1;
        end
        chk("bounce_c1", {3'b0, gotv == expv}, 4'b0001);
        step();
`endif

        // One-hot rotating row strobes during a code 6 press.
        key_valid = 1'b1;
        key_code  = 4'd6;
        r         = 4'b0001;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < LEN + 2; i++) begin
            r = 4'b0001 << ((i + 1) % 4);
            step();
        end

        // Back-to-back requests: code 0, then 15 held until accepted.
        r         = 4'b1111;
        key_valid = 1'b1;
        key_code  = 4'd0;
        step();
        key_code = 4'd15;
        for (int i = 0; i < LEN; i++) begin
            step();
            if (i == LEN - 1)
                chk("b2b_accept", {3'b0, s_done & s_rdy}, 4'b0001);
        end
        key_valid = 1'b0;
        key_code  = 4'd5;
        for (int i = 0; i < LEN + 1; i++) step();

        // Reset asserted in the middle of the contact-closed phase.
        key_valid = 1'b1;
        key_code  = 4'd10;
        r         = 4'b1111;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < LEN / 2; i++) step();
        reset_check("midrst");
        step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            key_valid = ($urandom_range(0, 3) != 0);
            key_code  = 4'($urandom_range(0, 15));
            r         = 4'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Behavioural-synthesizable 4x4 matrix keypad model that answers the row strobes R1..R4 on the column lines C1..C4, the way a physical keypad does. A test harness or on-chip self-test sequencer requests one key press at a time through a valid/ready handshake. The block holds the key closed for a programmed time, releases it, and enforces a release gap. It lets the keypad scan and decode path, and the calculator above it, run in simulation or self-test without a physical keypad.

## Interface
Parameters:
- HOLD_CYCLES, 64: clk cycles the contact stays solidly closed; legal range ≥ 1.
- GAP_CYCLES, 16: clk cycles of guaranteed release before the next request is accepted; legal range ≥ 1.
- BOUNCE_CYCLES, 8: length of each bounce window; legal range ≥ 2, even. Used only with KEYPAD_EMU_BOUNCE_EN.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- key_valid  in  1  press request.
- key_code  in  4  [3:2] = row index (0 → R1), [1:0] = column index (0 → C1).
- key_ready  out  1  high when a request can be accepted.
- key_done  out  1  one-cycle pulse when a press/release cycle finishes.
- R1, R2, R3, R4  in  1 each  row strobes from the scan pulser, active-high.
- C1, C2, C3, C4  out  1 each  column returns, active-high, registered.

## Operation
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- IDLE
  - key_ready = 1; contact = 0.
  - A handshake occurs on an edge with key_valid & key_ready. On that edge the block latches key_code and clears the cycle counter.
  - Next state: BOUNCE_IN with the macro defined, HOLD without it.
- BOUNCE_IN
  - Lasts BOUNCE_CYCLES cycles.
  - contact = ~cnt[1]: high 2 cycles, low 2 cycles, repeating, starting high.
  - Then goes to HOLD.
- HOLD: contact = 1 for HOLD_CYCLES cycles, then BOUNCE_OUT with the macro defined, GAP without it.
- BOUNCE_OUT: same toggle pattern as BOUNCE_IN for BOUNCE_CYCLES cycles, then GAP.
- GAP
  - contact = 0 for GAP_CYCLES cycles.
  - On the last GAP cycle the block asserts key_done for one cycle and moves to IDLE.
- Column rule, evaluated every cycle:
  - C[col] ← contact & R[row], using the latched row and column.
  - All other C lines ← 0.
  - Only the latched row is examined. Other rows being high, including several rows high at once, never produce a return.
- Counter: a single counter, sized to the largest parameter, cleared on every state change. Terminal condition is cnt == N−1.
- Boundary behaviour:
  - key_valid while key_ready = 0 is ignored, not queued. The requester holds key_valid until the handshake.
  - key_code changes after acceptance are ignored until the next handshake.
  - R lines changing mid-HOLD are tracked every cycle. The block models a closed switch, not a one-shot.
  - Reset asserted mid-press: immediately, asynchronously, the state goes to IDLE and C1..C4, key_done and contact go to 0. The latched code goes to 0.

## Timing
- Reset values:
  - key_ready = 1.
  - key_done = 0.
  - C1..C4 = 0.
  - state = IDLE.
- Handshake on edge E0.
  - key_ready falls after E0.
  - Without the macro, contact is high in cycles E0..E0+HOLD_CYCLES−1. The first possible C assertion is visible after edge E1, one register stage after R.
- Latency from R edge to C edge is one clk cycle in every state.
- key_done:
  - Without the macro, it pulses in the cycle ending at edge E0+HOLD_CYCLES+GAP_CYCLES.
  - key_ready is high from that edge on.
  - The earliest next handshake is that same edge.
- Request-to-request period:
  - Without the macro: HOLD_CYCLES + GAP_CYCLES.
  - With the macro: HOLD_CYCLES + GAP_CYCLES + 2·BOUNCE_CYCLES.

## Configuration
- KEYPAD_EMU_BOUNCE_EN defined:
  - BOUNCE_IN and BOUNCE_OUT are compiled in.
  - The contact toggles at press and release, exercising the downstream debounce.
- KEYPAD_EMU_BOUNCE_EN undefined:
  - Both bounce states and BOUNCE_CYCLES logic are removed.
  - The contact edges are clean: IDLE → HOLD → GAP.

## Test plan
- Reset with R1..R4 = 1111 → C1..C4 = 0000, key_ready = 1, key_done = 0; the same holds when reset is asserted mid-HOLD.
- No macro, HOLD_CYCLES = 4, GAP_CYCLES = 2, key_code = 4'b0110, R2 held high:
  - C3 = 1 after edges E1..E4, then 0.
  - key_done pulses at edge E6.
  - C1, C2, C4 stay 0 throughout.
- Same press with R1..R4 one-hot cycling each cycle:
  - C3 follows R2 delayed by one cycle, only during HOLD.
  - R1, R3, R4 never produce a return.
- key_valid held high with codes 0 then 15 back-to-back:
  - Second accepted exactly at the key_done edge.
  - C1 is driven for code 0, then C4 for code 15.
  - key_code changes mid-press have no effect.
- KEYPAD_EMU_BOUNCE_EN defined, BOUNCE_CYCLES = 8, HOLD_CYCLES = 4, R1 high, code 0:
  - C1 pattern 1,1,0,0,1,1,0,0, then 1×4, then 1,1,0,0,1,1,0,0, then 0.
  - Period is 4 + GAP_CYCLES + 16.
